// File: rtl/game_dumper.sv
// Streams an iNES image: a 16-byte header built from the inputs, then the
// PRG pages and the CHR pages, each byte read from memory one at a time.
module game_dumper (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  prgrom,
  input  logic [7:0]  chrrom,
  input  logic [7:0]  mapper,
  input  logic        mirroring,
  input  logic        four_screen,
  input  logic        has_saves,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, DONE, ERROR} state_t;

  localparam logic [21:0] CHR_BASE = 22'h200000;

  state_t      state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [21:0] addr_q, addr_d;
  logic [21:0] left_q, left_d;
  logic [7:0]  hold_q, hold_d;
  logic        chr_q, chr_d;

  logic [7:0]  hdr_byte;
  logic [21:0] left_dec;
  logic        xfer;
  logic        start_ok;

  always_comb begin
    case (hdr_idx_q)
      4'd0:    hdr_byte = 8'h4E;
      4'd1:    hdr_byte = 8'h45;
      4'd2:    hdr_byte = 8'h53;
      4'd3:    hdr_byte = 8'h1A;
      4'd4:    hdr_byte = prgrom;
      4'd5:    hdr_byte = chrrom;
      4'd6:    hdr_byte = {mapper[3:0], four_screen, 1'b0, has_saves, mirroring};
      4'd7:    hdr_byte = {mapper[7:4], 4'h0};
      default: hdr_byte = 8'h00;
    endcase
  end

  // Outputs are pure state decodes, so the async reset of the state clears them too.
  assign out_valid = (state_q == HDR) || (state_q == SEND);
  assign out_data  = (state_q == HDR)  ? hdr_byte :
                     (state_q == SEND) ? hold_q   : 8'h00;
  assign mem_rd    = (state_q == RD_REQ);
  assign mem_addr  = addr_q;
  assign busy      = (state_q == HDR) || (state_q == RD_REQ) ||
                     (state_q == RD_WAIT) || (state_q == SEND);
  assign done      = (state_q == DONE) || (state_q == ERROR);
  assign error     = (state_q == ERROR);

  assign xfer     = out_valid && out_ready;
  assign left_dec = left_q - 22'd1;
  assign start_ok = (prgrom != 8'd0) && (prgrom <= 8'd128);

  always_comb begin
    // NOTE: every next-state variable takes its held value first, so no path infers a latch.
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    addr_d    = addr_q;
    left_d    = left_q;
    hold_d    = hold_q;
    chr_d     = chr_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (start_ok) begin
              state_d   = HDR;
              hdr_idx_d = 4'd0;
            end else begin
              state_d = ERROR;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_idx_q == 4'd15) begin
              addr_d  = 22'd0;
              left_d  = {prgrom, 14'b0};
              chr_d   = 1'b0;
              state_d = RD_REQ;
            end else begin
              hdr_idx_d = hdr_idx_q + 4'd1;
            end
          end
        end
        RD_REQ:  state_d = RD_WAIT;
        RD_WAIT: begin
          if (mem_ack) begin
            hold_d  = mem_rdata;
            state_d = SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            addr_d = addr_q + 22'd1;
            left_d = left_dec;
            if (left_dec != 22'd0) begin
              state_d = RD_REQ;
            end else if (!chr_q && (chrrom != 8'd0)) begin
              addr_d  = CHR_BASE;
              left_d  = {1'b0, chrrom, 13'b0};
              chr_d   = 1'b1;
              state_d = RD_REQ;
            end else begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hdr_idx_q <= 4'd0;
      addr_q    <= 22'd0;
      left_q    <= 22'd0;
      hold_q    <= 8'h00;
      chr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      hold_q    <= hold_d;
      chr_q     <= chr_d;
    end
  end

endmodule

// File: tb/tb_game_dumper.sv
// Directed bench for game_dumper: header vector table, a full PRG+CHR dump,
// randomised back-pressure/latency, abort and mid-dump reset sequences.
module tb_game_dumper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  prgrom = 8'd0;
  logic [7:0]  chrrom = 8'd0;
  logic [7:0]  mapper = 8'd0;
  logic        mirroring = 1'b0;
  logic        four_screen = 1'b0;
  logic        has_saves = 1'b0;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'd0;
  logic        mem_ack = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, error;

  always #5 clk = ~clk;

  game_dumper dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .prgrom(prgrom), .chrrom(chrrom), .mapper(mapper),
    .mirroring(mirroring), .four_screen(four_screen), .has_saves(has_saves),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Memory and sink model state, owned by the negedge process below.
  bit          rand_ready = 1'b0;
  bit          rand_lat   = 1'b0;
  int          lat        = 1;
  bit          pend       = 1'b0;
  bit          had_pend;
  int          cnt;
  logic [21:0] pend_addr;
  int          xfer_cnt, valid_cnt, rd_cnt, data_err, addr_err, rd_viol, stall_viol;
  bit          stalled    = 1'b0;
  bit          abort_prev = 1'b0;
  logic [7:0]  last_data;
  logic [7:0]  hdr_cap [16];

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {a[21:16], 2'b00} ^ 8'h5A;
  endfunction

  function automatic logic [21:0] exp_addr(input int n);
    int p;
    int prg_bytes;
    p = n - 16;
    prg_bytes = int'(prgrom) * 16384;
    if (p < prg_bytes) return 22'(p);
    return 22'h200000 + 22'(p - prg_bytes);
  endfunction

  function automatic logic [7:0] exp_byte(input int n);
    if (n == 0) return 8'h4E;
    if (n == 1) return 8'h45;
    if (n == 2) return 8'h53;
    if (n == 3) return 8'h1A;
    if (n == 4) return prgrom;
    if (n == 5) return chrrom;
    if (n == 6) return {mapper[3:0], four_screen, 1'b0, has_saves, mirroring};
    if (n == 7) return {mapper[7:4], 4'h0};
    if (n < 16) return 8'h00;
    return mem_byte(exp_addr(n));
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0; mem_ack = 1'b0; stalled = 1'b0; abort_prev = 1'b0;
      end else begin
        had_pend = pend;
        if (mem_rd) begin
          rd_cnt++;
          if (had_pend) rd_viol++;
          if (mem_addr !== exp_addr(xfer_cnt)) addr_err++;
        end
        mem_ack = 1'b0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_byte(pend_addr);
            pend      = 1'b0;
          end
        end
        if (mem_rd && !had_pend) begin
          pend      = 1'b1;
          cnt       = rand_lat ? int'($urandom_range(1, 8)) : lat;
          pend_addr = mem_addr;
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid) begin
          valid_cnt++;
          if (stalled && out_data !== last_data) stall_viol++;
          if (out_ready) begin
            if (xfer_cnt < 16) hdr_cap[xfer_cnt] = out_data;
            if (out_data !== exp_byte(xfer_cnt)) data_err++;
            xfer_cnt++;
            stalled = 1'b0;
          end else begin
            stalled   = 1'b1;
            last_data = out_data;
          end
        end else begin
          if (stalled && !abort_prev) stall_viol++;
          stalled = 1'b0;
        end
        abort_prev = abort;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    xfer_cnt = 0; valid_cnt = 0; rd_cnt = 0;
    data_err = 0; addr_err = 0; rd_viol = 0; stall_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [7:0] c, input logic [7:0] m,
                         input logic mi, input logic fs, input logic hs);
    prgrom = p; chrrom = c; mapper = m;
    mirroring = mi; four_screen = fs; has_saves = hs;
  endtask

  task automatic wait_xfer(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (xfer_cnt < n && c < budget) begin
      tick();
      c++;
    end
    check({name, "_reached"}, 64'(xfer_cnt >= n), 64'd1);
  endtask

  task automatic wait_quiet();
    int c;
    c = 0;
    while (pend && c < 50) begin
      tick();
      c++;
    end
    check("ack_drained", 64'(pend), 64'd0);
  endtask

  typedef struct {
    logic [7:0] prg, chr, map;
    logic       mir, fs, hs, err;
    logic [7:0] b6, b7;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int snap;
    int c;
    vecs[0] = '{8'd0,   8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[1] = '{8'd200, 8'd1,   8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[2] = '{8'd129, 8'd0,   8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{8'd128, 8'd255, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'hA0};
    vecs[4] = '{8'd1,   8'd0,   8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 8'h00};
    vecs[5] = '{8'd16,  8'd8,   8'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE2, 8'h10};
    vecs[6] = '{8'd2,   8'd3,   8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h09, 8'hF0};

    // Reset state, then idle after release.
    tick(2);
    check("reset_outputs", {mem_addr, mem_rd, out_data, out_valid, busy, done, error}, 64'd0);
    reset_n = 1'b1;
    tick(3);
    check("idle_after_release", {out_valid, mem_rd, busy, done, error}, 64'd0);

    // Header/error vector table.
    foreach (vecs[i]) begin
      set_cfg(vecs[i].prg, vecs[i].chr, vecs[i].map, vecs[i].mir, vecs[i].fs, vecs[i].hs);
      clear_counts();
      pulse_start();
      if (vecs[i].err) begin
        check($sformatf("v%0d_err_status", i), {error, done, busy}, 64'b110);
        tick(4);
        check($sformatf("v%0d_err_quiet", i), {32'(rd_cnt), 32'(valid_cnt)}, 64'd0);
      end else begin
        check($sformatf("v%0d_hdr_status", i), {busy, done, error, out_data}, {3'b100, 8'h4E});
        wait_xfer($sformatf("v%0d_hdr", i), 16, 200);
        check($sformatf("v%0d_hdr_4to7", i), {hdr_cap[4], hdr_cap[5], hdr_cap[6], hdr_cap[7]},
              {vecs[i].prg, vecs[i].chr, vecs[i].b6, vecs[i].b7});
        check($sformatf("v%0d_hdr_bytes", i), 64'(data_err), 64'd0);
        pulse_abort();
        check($sformatf("v%0d_abort_idle", i), {busy, done, error, out_valid, mem_rd}, 64'd0);
        wait_quiet();
      end
    end

    // Abort while header byte 9 is presented; restart begins at byte 0.
    set_cfg(8'd1, 8'd1, 8'h04, 1'b1, 1'b0, 1'b0);
    clear_counts();
    pulse_start();
    wait_xfer("hdr9", 9, 50);
    pulse_abort();
    check("hdr9_abort_idle", {busy, done, out_valid, mem_rd}, 64'd0);
    snap = valid_cnt;
    tick(3);
    check("hdr9_no_valid", 64'(valid_cnt), 64'(snap));
    clear_counts();
    pulse_start();
    check("hdr9_restart_byte0", {busy, out_data}, {1'b1, 8'h4E});
    wait_xfer("hdr9_restart", 20, 200);
    check("hdr9_restart_data", 64'(data_err), 64'd0);
    pulse_abort();
    wait_quiet();

    // Abort in RD_WAIT; the late mem_ack must not revive the stream.
    lat = 6;
    clear_counts();
    pulse_start();
    wait_xfer("rdwait_hdr", 16, 100);
    tick();
    check("rdwait_state", {busy, mem_rd, out_valid}, 64'b100);
    pulse_abort();
    check("rdwait_abort_idle", {busy, done, out_valid}, 64'd0);
    snap = valid_cnt;
    tick(8);
    check("rdwait_late_ack", {32'(valid_cnt), 29'd0, busy, done, error}, {32'(snap), 32'd0});
    lat = 1;
    clear_counts();
    pulse_start();
    wait_xfer("rdwait_restart", 20, 200);
    check("rdwait_restart_data", 64'(data_err), 64'd0);
    pulse_abort();
    wait_quiet();

    // Full dump: 1 PRG page and 1 CHR page.
    clear_counts();
    pulse_start();
    c = 0;
    while (!done && c < 80000) begin
      tick();
      c++;
    end
    check("full_done", {done, busy, error}, 64'b100);
    check("full_xfers", 64'(xfer_cnt), 64'd24592);
    check("full_reads", 64'(rd_cnt), 64'd24576);
    check("full_data", 64'(data_err), 64'd0);
    check("full_addr", 64'(addr_err), 64'd0);
    check("full_one_outstanding", 64'(rd_viol), 64'd0);
    tick(3);
    check("full_done_held", {done, busy, out_valid}, 64'b100);

    // Random back-pressure and latency, restarted from DONE; a start mid-dump is ignored.
    set_cfg(8'd1, 8'd2, 8'h12, 1'b0, 1'b1, 1'b0);
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    clear_counts();
    pulse_start();
    check("rand_restart_status", {busy, done, error}, 64'b100);
    wait_xfer("rand_mid", 50, 2000);
    pulse_start();
    wait_xfer("rand_end", 400, 10000);
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    pulse_abort();
    check("rand_data", 64'(data_err), 64'd0);
    check("rand_stall_stable", 64'(stall_viol), 64'd0);
    check("rand_one_outstanding", 64'(rd_viol), 64'd0);
    check("rand_addr", 64'(addr_err), 64'd0);
    wait_quiet();

    // Asynchronous reset in the middle of PRG, then a fresh dump.
    clear_counts();
    pulse_start();
    wait_xfer("rst_mid", 1000, 4000);
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", {mem_addr, mem_rd, out_data, out_valid, busy, done, error}, 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("rst_stays_idle", {busy, done, error, out_valid, mem_rd}, 64'd0);
    clear_counts();
    pulse_start();
    wait_xfer("rst_redump", 600, 3000);
    check("rst_redump_data", 64'(data_err), 64'd0);
    check("rst_redump_addr", 64'(addr_err), 64'd0);
    pulse_abort();
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
